csr_trap_unit: RTL and testbench
================================

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0100, reset value of mtvec.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc_in  input  32  PC of the instruction in the current cycle.
REQ-005 SHALL have port redirect  input  1  branch or jump taken this cycle (br_true | jump_en).
REQ-006 SHALL have port is_mret  input  1  current instruction is MRET.
REQ-007 SHALL have ports csr_rd / csr_wr  input  1 each  CSR read / write strobe for the current instruction.
REQ-008 SHALL have port csr_addr  input  12  CSR address.
REQ-009 SHALL have port csr_wdata  input  32  CSR write data.
REQ-010 SHALL have ports timer_irq / ext_irq  input  1 each  level-sensitive interrupt requests.
REQ-011 SHALL have port csr_rdata  output  32  CSR read data.
REQ-012 SHALL have port epc  output  32  redirect target for the PC select logic.
REQ-013 SHALL have port epc_taken  output  1  redirect PC to epc.
REQ-014 SHALL have port trap_flush  output  1  suppress commit of the current instruction.

Function
REQ-015 SHALL implement the following CSRs:
- mstatus 0x300: MIE bit3, MPIE bit7; other bits read 0.
- mie 0x304: MTIE bit7, MEIE bit11.
- mtvec 0x305: bits[1:0] forced 0, direct mode only.
- mepc 0x341: bits[1:0] forced 0.
- mcause 0x342.
- mip 0x344: read-only; MTIP bit7, MEIP bit11.
- mcycle 0xB00 / mcycleh 0xB80.
REQ-016 SHALL register timer_irq/ext_irq into mip.MTIP/MEIP every cycle (one-cycle latency; level, not edge).
REQ-017 SHALL compute irq_req = MIE & ((MEIE & MEIP) | (MTIE & MTIP)).
REQ-018 SHALL drive csr_rdata combinationally with pre-write contents when csr_rd=1, else 0; unimplemented addresses read 0.
REQ-019 SHALL apply a CSR write at the clock edge when csr_wr=1 and no trap is taken that cycle; writes to mip or unimplemented addresses are ignored.
REQ-020 SHALL select per cycle with priority MRET > trap > normal:
- MRET: is_mret=1.
- Trap: irq_req=1, redirect=0, is_mret=0.
REQ-021 MRET cycle: epc_taken=1, epc=mepc, trap_flush=0; at edge MIE<=MPIE, MPIE<=1.
REQ-022 Trap cycle: epc_taken=1, epc=mtvec, trap_flush=1; at edge:
- mepc<=pc_in.
- mcause<=32'h8000_000B if external is pending and enabled, else 32'h8000_0007 (external beats timer).
- MPIE<=MIE, MIE<=0.
- Any csr_wr that cycle is dropped.
REQ-023 SHALL defer a trap while redirect=1 (the external PC select gives branch/jump priority); the trap is taken in the first later cycle in which REQ-020 holds.
REQ-024 Normal cycle: epc_taken=0, trap_flush=0, epc=mepc.
REQ-025 mcycle counter:
- 64-bit {mcycleh,mcycle}, +1 every cycle; carry from low to high word; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- A write to either half replaces that half and suppresses that cycle's increment of the whole counter.
REQ-026 SHALL produce epc_taken as a single-cycle assertion per MRET/trap event; consecutive events are allowed.

Reset
REQ-027 While rst=1:
- mstatus, mie, mepc, mcause, mip, mcycle/mcycleh = 0; mtvec = MTVEC_RESET.
- epc_taken=0, trap_flush=0, epc=0, csr_rdata=0.
REQ-028 Reset asserted mid-trap or mid-MRET SHALL discard the event; the first edge after deassert resumes normal operation with no pending state retained.

Verification
REQ-029 Write mie=0x800, mstatus=0x8; hold ext_irq=1, pc_in=0x40 -> next cycle:
- epc_taken=1, epc=0x100, trap_flush=1.
- After the edge: mepc=0x40, mcause=0x8000000B, mstatus=0x80.
REQ-030 Then is_mret=1 -> epc_taken=1, epc=0x40; after the edge mstatus=0x88.
REQ-031 Timer and external pending together, both enabled -> mcause=0x8000000B; deassert ext, re-enable MIE -> next trap mcause=0x80000007.
REQ-032 irq_req with redirect=1 for 3 cycles -> epc_taken=0 for those cycles; trap taken in the first cycle redirect=0, mepc=that cycle's pc_in.
REQ-033 Write mcycle=0xFFFFFFFF, mcycleh=0 -> two cycles later mcycleh=1, mcycle=0x00000001.
REQ-034 Write mtvec=0x203 -> reads 0x200; rst pulse mid-run -> all CSRs at reset values, epc_taken=0.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt trap entry, MRET return and a 64-bit cycle counter.
// Trap and MRET decisions are combinational so the PC select can redirect in the same cycle.
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        redirect,
    input  logic        is_mret,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic [31:0] epc,
    output logic        epc_taken,
    output logic        trap_flush
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic        mtie_q, mtie_d, meie_q, meie_d;
    logic        mtip_q, mtip_d, meip_q, meip_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;

    logic        ext_pend_s, irq_req_s, take_mret_s, take_trap_s, wr_en_s;
    logic [31:0] rd_val_s;

    // Event selection: MRET beats a trap, and a taken branch/jump defers the trap.
    always_comb begin
        ext_pend_s  = meie_q & meip_q;
        irq_req_s   = mie_q & (ext_pend_s | (mtie_q & mtip_q));
        take_mret_s = is_mret;
        take_trap_s = irq_req_s & ~redirect & ~is_mret;
        wr_en_s     = csr_wr & ~take_trap_s;
    end

    // Read mux over pre-write CSR contents.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (csr_addr)
            ADDR_MSTATUS: rd_val_s = {24'h00_0000, mpie_q, 3'b000, mie_q, 3'b000};
            ADDR_MIE:     rd_val_s = {20'h0_0000, meie_q, 3'b000, mtie_q, 7'b000_0000};
            ADDR_MTVEC:   rd_val_s = mtvec_q;
            ADDR_MEPC:    rd_val_s = mepc_q;
            ADDR_MCAUSE:  rd_val_s = mcause_q;
            ADDR_MIP:     rd_val_s = {20'h0_0000, meip_q, 3'b000, mtip_q, 7'b000_0000};
            ADDR_MCYCLE:  rd_val_s = mcycle_q[31:0];
            ADDR_MCYCLEH: rd_val_s = mcycle_q[63:32];
            default:      rd_val_s = 32'h0000_0000;
        endcase
    end

    // Outputs are forced quiet while reset is held so a pending event cannot leak out.
    always_comb begin
        if (rst) begin
            csr_rdata  = 32'h0000_0000;
            epc        = 32'h0000_0000;
            epc_taken  = 1'b0;
            trap_flush = 1'b0;
        end else begin
            csr_rdata  = csr_rd ? rd_val_s : 32'h0000_0000;
            epc        = take_trap_s ? mtvec_q : mepc_q;
            epc_taken  = take_mret_s | take_trap_s;
            trap_flush = take_trap_s;
        end
    end

    // Next-state: software write first, then MRET/trap side effects override mstatus.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtie_d   = mtie_q;
        meie_d   = meie_q;
        mtip_d   = timer_irq;
        meip_d   = ext_irq;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mcycle_d = mcycle_q + 64'd1;
        if (wr_en_s) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                ADDR_MIE: begin
                    mtie_d = csr_wdata[7];
                    meie_d = csr_wdata[11];
                end
                ADDR_MTVEC:   mtvec_d  = csr_wdata & 32'hFFFF_FFFC;
                ADDR_MEPC:    mepc_d   = csr_wdata & 32'hFFFF_FFFC;
                ADDR_MCAUSE:  mcause_d = csr_wdata;
                ADDR_MCYCLE:  mcycle_d = {mcycle_q[63:32], csr_wdata};
                ADDR_MCYCLEH: mcycle_d = {csr_wdata, mcycle_q[31:0]};
                default:      mcause_d = mcause_q;
            endcase
        end else begin
            mcause_d = mcause_q;
        end
        if (take_mret_s) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (take_trap_s) begin
            mepc_d   = pc_in & 32'hFFFF_FFFC;
            mcause_d = ext_pend_s ? CAUSE_EXT : CAUSE_TIMER;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else begin
            mepc_d = mepc_d;
        end
    end

    // CSR state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtip_q   <= 1'b0;
            meip_q   <= 1'b0;
            mtvec_q  <= MTVEC_RESET;
            mepc_q   <= 32'h0000_0000;
            mcause_q <= 32'h0000_0000;
            mcycle_q <= 64'h0000_0000_0000_0000;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtie_q   <= mtie_d;
            meie_q   <= meie_d;
            mtip_q   <= mtip_d;
            meip_q   <= meip_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mcycle_q <= mcycle_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench: stimulus pushes expected per-cycle outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        redirect, is_mret, csr_rd, csr_wr;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        timer_irq, ext_irq;
    logic [31:0] csr_rdata, epc;
    logic        epc_taken, trap_flush;

    typedef struct {
        int          cyc;
        string       name;
        logic        taken;
        logic        flush;
        logic [31:0] epc;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   total = 0;
    int   bad = 0;

    csr_trap_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .redirect(redirect), .is_mret(is_mret),
        .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .timer_irq(timer_irq), .ext_irq(ext_irq), .csr_rdata(csr_rdata), .epc(epc),
        .epc_taken(epc_taken), .trap_flush(trap_flush)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(string nm, string field, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, req);
        end
    endtask

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc_cnt) begin
                total++;
                bad++;
                $display("FAIL %s.stale: checked at cycle %0d, required %0d", e.name, cyc_cnt, e.cyc);
            end else begin
                chk(e.name, "epc_taken", {31'd0, epc_taken}, {31'd0, e.taken});
                chk(e.name, "trap_flush", {31'd0, trap_flush}, {31'd0, e.flush});
                chk(e.name, "epc", epc, e.epc);
                chk(e.name, "csr_rdata", csr_rdata, e.rdata);
            end
        end
    end

    task automatic rd(logic [11:0] a);
        csr_rd   = 1'b1;
        csr_addr = a;
    endtask

    task automatic wr(logic [11:0] a, logic [31:0] d);
        csr_wr    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
    endtask

    task automatic clr();
        csr_rd    = 1'b0;
        csr_wr    = 1'b0;
        is_mret   = 1'b0;
        redirect  = 1'b0;
        csr_addr  = 12'h000;
        csr_wdata = 32'h0000_0000;
    endtask

    task automatic step(string nm, logic et, logic tf, logic [31:0] ep, logic [31:0] rdv);
        exp_t e;
        e.cyc = cyc_cnt; e.name = nm; e.taken = et; e.flush = tf; e.epc = ep; e.rdata = rdv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        rst = 1'b1; pc_in = 32'h0; timer_irq = 1'b0; ext_irq = 1'b0;
        clr();
        @(posedge clk); #1;
        rd(12'h305);                    step("reset_quiet", 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        rd(12'h305);                    step("mtvec_rst", 1'b0, 1'b0, 32'h0, 32'h100);
        // External interrupt trap and MRET round trip
        wr(12'h304, 32'h800);           step("wr_mie", 1'b0, 1'b0, 32'h0, 32'h0);
        wr(12'h300, 32'h8);             step("wr_mstatus", 1'b0, 1'b0, 32'h0, 32'h0);
        ext_irq = 1'b1; pc_in = 32'h40; step("mip_latency", 1'b0, 1'b0, 32'h0, 32'h0);
        wr(12'h300, 32'h0);             step("ext_trap", 1'b1, 1'b1, 32'h100, 32'h0);
        ext_irq = 1'b0; rd(12'h341);    step("mepc_trap", 1'b0, 1'b0, 32'h40, 32'h40);
        rd(12'h342);                    step("mcause_ext", 1'b0, 1'b0, 32'h40, 32'h8000_000B);
        rd(12'h300);                    step("mstatus_trap", 1'b0, 1'b0, 32'h40, 32'h80);
        is_mret = 1'b1; rd(12'h300);    step("mret", 1'b1, 1'b0, 32'h40, 32'h80);
        rd(12'h300);                    step("mstatus_mret", 1'b0, 1'b0, 32'h40, 32'h88);
        // Timer and external together: external wins, then timer alone
        wr(12'h304, 32'h880); timer_irq = 1'b1; ext_irq = 1'b1; pc_in = 32'h80;
                                        step("wr_mie_both", 1'b0, 1'b0, 32'h40, 32'h0);
        ext_irq = 1'b0;                 step("both_trap", 1'b1, 1'b1, 32'h100, 32'h0);
        rd(12'h342);                    step("mcause_both", 1'b0, 1'b0, 32'h80, 32'h8000_000B);
        wr(12'h300, 32'h88); pc_in = 32'hC0;
                                        step("reenable_mie", 1'b0, 1'b0, 32'h80, 32'h0);
        timer_irq = 1'b0;               step("timer_trap", 1'b1, 1'b1, 32'h100, 32'h0);
        rd(12'h342);                    step("mcause_timer", 1'b0, 1'b0, 32'hC0, 32'h8000_0007);
        // Trap deferred while redirect is high
        wr(12'h300, 32'h88); timer_irq = 1'b1;
                                        step("arm_timer", 1'b0, 1'b0, 32'hC0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            redirect = 1'b1; pc_in = 32'h100 + 32'(4 * i);
            step("redirect_defer", 1'b0, 1'b0, 32'hC0, 32'h0);
        end
        pc_in = 32'h10C; timer_irq = 1'b0;
                                        step("deferred_trap", 1'b1, 1'b1, 32'h100, 32'h0);
        rd(12'h341);                    step("mepc_deferred", 1'b0, 1'b0, 32'h10C, 32'h10C);
        // Cycle counter carry
        wr(12'hB00, 32'hFFFF_FFFF);     step("wr_mcycle", 1'b0, 1'b0, 32'h10C, 32'h0);
        wr(12'hB80, 32'h0);             step("wr_mcycleh", 1'b0, 1'b0, 32'h10C, 32'h0);
        rd(12'hB00);                    step("mcycle_held", 1'b0, 1'b0, 32'h10C, 32'hFFFF_FFFF);
        rd(12'hB80);                    step("mcycleh_carry", 1'b0, 1'b0, 32'h10C, 32'h1);
        rd(12'hB00);                    step("mcycle_after", 1'b0, 1'b0, 32'h10C, 32'h1);
        // mtvec alignment, mip read-only, unimplemented address
        wr(12'h305, 32'h203);           step("wr_mtvec", 1'b0, 1'b0, 32'h10C, 32'h0);
        rd(12'h305);                    step("mtvec_align", 1'b0, 1'b0, 32'h10C, 32'h200);
        wr(12'h344, 32'hFFFF_FFFF);     step("wr_mip", 1'b0, 1'b0, 32'h10C, 32'h0);
        rd(12'h344);                    step("mip_ro", 1'b0, 1'b0, 32'h10C, 32'h0);
        rd(12'h123);                    step("unimpl", 1'b0, 1'b0, 32'h10C, 32'h0);
        // Reset pulse in the middle of an MRET
        rst = 1'b1; is_mret = 1'b1; rd(12'h305);
                                        step("rst_mret", 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0; rd(12'h305);        step("mtvec_rst2", 1'b0, 1'b0, 32'h0, 32'h100);
        rd(12'h300);                    step("mstatus_rst", 1'b0, 1'b0, 32'h0, 32'h0);
        rd(12'h342);                    step("mcause_rst", 1'b0, 1'b0, 32'h0, 32'h0);
        rd(12'h304);                    step("mie_rst", 1'b0, 1'b0, 32'h0, 32'h0);
        rd(12'hB00);                    step("mcycle_rst", 1'b0, 1'b0, 32'h0, 32'h4);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
